count_seq_ctrl: RTL

- Command-driven sequencer for the 8-bit output counter datapath on uo_out.
- Accepts start/stop/resume/clear/configure commands over a valid/ready interface.
- Paces counter increments through a programmable prescaler and enforces a programmable terminal count, either wrapping or one-shot.
- Sits between the ui_in command decode and the counter register; the counter itself stays a plain enable/clear register.

---
 rtl/count_seq_pkg.sv | 27 ++
 rtl/count_seq_prescaler.sv | 51 +++++
 rtl/count_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// Shared definitions for the counter sequencer: opcodes, state encoding,
// counting modes and configuration reset defaults.
package count_seq_pkg;

    localparam logic [2:0] OP_START      = 3'd0;
    localparam logic [2:0] OP_STOP       = 3'd1;
    localparam logic [2:0] OP_RESUME     = 3'd2;
    localparam logic [2:0] OP_CLEAR      = 3'd3;
    localparam logic [2:0] OP_LOAD_LIMIT = 3'd4;
    localparam logic [2:0] OP_LOAD_DIV   = 3'd5;
    localparam logic [2:0] OP_SET_MODE   = 3'd6;
    localparam logic [2:0] OP_NOP        = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam logic [7:0] LIMIT_RST = 8'hFF;
    localparam logic [7:0] DIV_RST   = 8'h00;

endpackage

// File: rtl/count_seq_prescaler.sv
// Programmable prescaler: counts 0..div while running and raises tick on the
// match. Freeze holds the count, reload returns it to zero.
module count_seq_prescaler
    import count_seq_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       div_we,
    input  logic [7:0] div_wdata,
    input  logic       run,
    input  logic       freeze,
    input  logic       reload,
    output logic       tick
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pre_r;

    // A freshly written div only affects the compare on the following cycle;
    // a count already past it rolls through the full range before matching.
    assign tick = run && (pre_r == div_r);

    // Divide register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r <= DIV_W'(DIV_RST);
        end else if (div_we) begin
            div_r <= DIV_W'(div_wdata);
        end else begin
            div_r <= div_r;
        end
    end

    // Prescaler count: reload beats freeze beats advance; parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_r <= {DIV_W{1'b0}};
        end else if (reload) begin
            pre_r <= {DIV_W{1'b0}};
        end else if (freeze) begin
            pre_r <= pre_r;
        end else if (run) begin
            pre_r <= pre_r + DIV_W'(1);
        end else begin
            pre_r <= {DIV_W{1'b0}};
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Command-driven sequencer for the output counter: decodes commands, paces
// increments through the prescaler and enforces the terminal count.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] count_in,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             done,
    output logic             wrap_pulse
);

    state_e           state_r;
    logic             done_r;
    logic             ready_r;
    logic [CNT_W-1:0] limit_r;
    logic             mode_r;

    logic cmd_acc_s;
    logic start_s, stop_s, resume_s, clear_s;
    logic ld_lim_s, ld_div_s, set_mode_s;
    logic tick_s, fire_s, at_lim_s;

    assign cmd_ready = ready_r & rst_n;
    assign cmd_acc_s = cmd_valid & cmd_ready;
    assign state     = state_r;
    assign done      = done_r;

    // Command decode; STOP and RESUME only count in the state they act on.
    always_comb begin
        start_s    = 1'b0;
        stop_s     = 1'b0;
        resume_s   = 1'b0;
        clear_s    = 1'b0;
        ld_lim_s   = 1'b0;
        ld_div_s   = 1'b0;
        set_mode_s = 1'b0;
        if (cmd_acc_s) begin
            case (cmd_op)
                OP_START:      start_s    = 1'b1;
                OP_STOP:       stop_s     = (state_r == ST_RUN);
                OP_RESUME:     resume_s   = (state_r == ST_HOLD);
                OP_CLEAR:      clear_s    = 1'b1;
                OP_LOAD_LIMIT: ld_lim_s   = 1'b1;
                OP_LOAD_DIV:   ld_div_s   = 1'b1;
                OP_SET_MODE:   set_mode_s = 1'b1;
                default:       start_s    = 1'b0;
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    count_seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_we    (ld_div_s),
        .div_wdata (cmd_data),
        .run       (state_r == ST_RUN),
        .freeze    ((state_r == ST_HOLD) | stop_s),
        .reload    (start_s | clear_s | (tick_s & ~stop_s)),
        .tick      (tick_s)
    );

    // A state-changing command in the same cycle swallows the tick.
    assign fire_s   = tick_s & ~(start_s | stop_s | clear_s);
    assign at_lim_s = (count_in == limit_r);

    // Datapath strobes; clear always dominates increment.
    always_comb begin
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        wrap_pulse = 1'b0;
        if (!rst_n) begin
            cnt_clr = 1'b1;
        end else if (start_s || clear_s) begin
            cnt_clr = 1'b1;
        end else if (fire_s && !at_lim_s) begin
            cnt_inc = 1'b1;
        end else if (fire_s && (mode_r == MODE_WRAP)) begin
            cnt_clr    = 1'b1;
            wrap_pulse = 1'b1;
        end else begin
            cnt_inc = 1'b0;
        end
    end

    // Sequencer FSM with registered done and ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            ready_r <= ~cmd_acc_s;
            if (start_s || resume_s) begin
                state_r <= ST_RUN;
                done_r  <= 1'b0;
            end else if (clear_s) begin
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
            end else if (stop_s) begin
                state_r <= ST_HOLD;
                done_r  <= 1'b0;
            end else if (fire_s && at_lim_s && (mode_r == MODE_ONESHOT)) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
            end else begin
                state_r <= state_r;
                done_r  <= (state_r == ST_DONE);
            end
        end
    end

    // Limit and mode configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            limit_r <= CNT_W'(LIMIT_RST);
            mode_r  <= MODE_WRAP;
        end else begin
            if (ld_lim_s) begin
                limit_r <= CNT_W'(cmd_data);
            end else begin
                limit_r <= limit_r;
            end
            if (set_mode_s) begin
                mode_r <= cmd_data[0];
            end else begin
                mode_r <= mode_r;
            end
        end
    end

endmodule
